// File: rtl/cpu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctrl -- multi-cycle CPU sequencer.
//
// Steps one instruction at a time through FETCH -> DECODE -> EXEC -> (MEM) ->
// (WB) -> FETCH. It drives the datapath strobes and the ALU operand selects,
// and counts retired instructions. An illegal opcode or a memory wait longer
// than TIMEOUT cycles sends it to TRAP. TRAP is absorbing until reset.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   opcode[6:0]             : opcode of the latched instruction register
//   imem_ack, dmem_ack      : single-cycle memory completion strobes
//   state[2:0]              : current state (FETCH=0 .. TRAP=5)
//   imem_req, ir_we         : instruction fetch request / IR write
//   dmem_req, dmem_we       : data memory request / write
//   rf_we, pc_we            : register file write / PC write
//   op1_type, op2_type[1:0] : ALU operand selects (NONE=0 REG=1 IMM=2 PC=3)
//   trap_illegal, trap_bus  : sticky error flags
//   retire_cnt[31:0]        : count of retired instructions
//
// Handshake: each memory request is held high for as long as the sequencer
// sits in its wait state (FETCH for imem, MEM for dmem). The matching ack is
// a one-cycle strobe that completes the access in the cycle it is sampled
// high. An ack that arrives outside its own wait state has no effect.
// ---------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic [2:0]  state,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  op1_type,
    output logic [1:0]  op2_type,
    output logic        trap_illegal,
    output logic        trap_bus,
    output logic [31:0] retire_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    // A wait of TIMEOUT cycles traps when the cycle that would bring the
    // counter to TIMEOUT also has no ack, so compare against TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        run_q;
    logic        trap_illegal_q, trap_illegal_d;
    logic        trap_bus_q, trap_bus_d;
    logic [31:0] retire_q;

    logic is_load, is_store, is_branch, is_legal;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);

    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_legal = 1'b1;
            default:                                 is_legal = 1'b0;
        endcase
    end

    // Next-state logic. The wait counter is cleared on every entry into
    // FETCH or MEM, and advances only during cycles without an ack.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        trap_illegal_d = trap_illegal_q;
        trap_bus_d     = trap_bus_q;
        case (state_q)
            ST_FETCH: begin
                // run_q holds off the first wait cycle until the first
                // clock edge after reset release.
                if (run_q) begin
                    if (imem_ack) begin
                        state_d = ST_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d    = ST_TRAP;
                        trap_bus_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d        = ST_TRAP;
                    trap_illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                    wait_d  = 8'd0;
                end else if (is_branch) begin
                    state_d = ST_FETCH;
                    wait_d  = 8'd0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        wait_d  = 8'd0;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = ST_TRAP;
                    trap_bus_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                wait_d  = 8'd0;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FETCH;
            wait_q         <= 8'd0;
            run_q          <= 1'b0;
            trap_illegal_q <= 1'b0;
            trap_bus_q     <= 1'b0;
            retire_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            run_q          <= 1'b1;
            trap_illegal_q <= trap_illegal_d;
            trap_bus_q     <= trap_bus_d;
            if (pc_we) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    // Strobes decode the registered state, so an asynchronous reset drops
    // them at once. ir_we and the STORE completion pc_we also follow the ack.
    assign imem_req = run_q && (state_q == ST_FETCH);
    assign ir_we    = imem_req && imem_ack;
    assign dmem_req = (state_q == ST_MEM);
    assign dmem_we  = (state_q == ST_MEM) && is_store;
    assign rf_we    = (state_q == ST_WB);
    assign pc_we    = (state_q == ST_WB)
                   || ((state_q == ST_EXEC) && is_branch)
                   || ((state_q == ST_MEM) && is_store && dmem_ack);

    always_comb begin
        op1_type = OP_TYPE_NONE;
        op2_type = OP_TYPE_NONE;
        if (state_q == ST_DECODE || state_q == ST_EXEC ||
            state_q == ST_MEM || state_q == ST_WB) begin
            case (opcode)
                OPC_OP, OPC_BRANCH: begin
                    op1_type = OP_TYPE_REG;
                    op2_type = OP_TYPE_REG;
                end
                OPC_OPIMM, OPC_LOAD, OPC_STORE: begin
                    op1_type = OP_TYPE_REG;
                    op2_type = OP_TYPE_IMM;
                end
                OPC_LUI: begin
                    op2_type = OP_TYPE_IMM;
                end
                OPC_AUIPC: begin
                    op1_type = OP_TYPE_PC;
                    op2_type = OP_TYPE_IMM;
                end
                OPC_JAL, OPC_JALR: begin
                    op1_type = OP_TYPE_PC;
                end
                default: begin
                    op1_type = OP_TYPE_NONE;
                    op2_type = OP_TYPE_NONE;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign trap_illegal = trap_illegal_q;
    assign trap_bus     = trap_bus_q;
    assign retire_cnt   = retire_q;

endmodule
